switch_debounce: RTL and testbench



---
 rtl/switch_pkg.sv | 13 +
 rtl/switch_debounce_bit.sv | 55 +++++
 rtl/switch_debounce.sv | 44 ++++
 tb/tb_switch_debounce.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared constants for the slide-switch conditioning block.
package switch_pkg;

    localparam int SW_WIDTH                = 16;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 240000;
    localparam int DEBOUNCE_CYCLES_SIM     = 8;

    // Stability counter width; holds values up to DEBOUNCE_CYCLES-1 with headroom.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, stable level and edge strobes.
module switch_debounce_bit
    import switch_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic sw_stable,
    output logic sw_rise,
    output logic sw_fall,
    output logic settle
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p1;
    logic             sync_p2;
    logic [CNT_W-1:0] cnt;
    logic             differ;

    assign differ = (sync_p2 != sw_stable);
    // High in the cycle before sw_stable takes the new level; the top registers it too.
    assign settle = differ && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p1   <= RESET_VALUE;
            sync_p2   <= RESET_VALUE;
            sw_stable <= RESET_VALUE;
            cnt       <= '0;
            sw_rise   <= 1'b0;
            sw_fall   <= 1'b0;
        end else begin
            // stage p1/p2: metastability synchroniser
            sync_p1 <= sw_raw;
            sync_p2 <= sync_p1;
            // stage p3: stability counter and stable level
            sw_rise <= settle && sync_p2;
            sw_fall <= settle && !sync_p2;
            if (settle) begin
                sw_stable <= sync_p2;
                cnt       <= '0;
            end else if (differ) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Debounces SW_WIDTH slide switches and flags any settled level change.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int                  SW_WIDTH        = switch_pkg::SW_WIDTH,
    parameter int                  DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic [SW_WIDTH-1:0] RESET_VALUE     = {SW_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic [SW_WIDTH-1:0] sw_stable,
    output logic [SW_WIDTH-1:0] sw_rise,
    output logic [SW_WIDTH-1:0] sw_fall,
    output logic                sw_changed
);

    logic [SW_WIDTH-1:0] settle;

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VALUE    (RESET_VALUE[i])
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .sw_raw   (sw_raw[i]),
            .sw_stable(sw_stable[i]),
            .sw_rise  (sw_rise[i]),
            .sw_fall  (sw_fall[i]),
            .settle   (settle[i])
        );
    end

    // Registered from the pre-strobe settle terms so it lines up with sw_rise/sw_fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= |settle;
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=8, plus a DEBOUNCE_CYCLES=1 instance.
module tb_switch_debounce;
    import switch_pkg::*;

    typedef struct {
        logic        rst;
        logic [15:0] raw;
        logic [15:0] stable;
        logic [15:0] rise;
        logic [15:0] fall;
        logic        chg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw_raw;
    logic [15:0] sw_stable, sw_rise, sw_fall;
    logic        sw_changed;
    logic [15:0] q_stable, q_rise, q_fall;
    logic        q_changed;

    int checks   = 0;
    int failures = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    switch_debounce #(
        .SW_WIDTH       (16),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM),
        .RESET_VALUE    (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .sw_stable (sw_stable),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed)
    );

    switch_debounce #(
        .SW_WIDTH       (16),
        .DEBOUNCE_CYCLES(1),
        .RESET_VALUE    (16'h0000)
    ) dut_fast (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .sw_stable (q_stable),
        .sw_rise   (q_rise),
        .sw_fall   (q_fall),
        .sw_changed(q_changed)
    );

    task automatic chk(input string name, input int edge_no, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h want=%h", name, edge_no, act, exp);
        end
    endtask

    task automatic chk_main(input string tag, input int e, input logic [15:0] st, input logic [15:0] ri,
                            input logic [15:0] fa, input logic ch);
        chk({tag, ".stable"},  e, sw_stable, st);
        chk({tag, ".rise"},    e, sw_rise, ri);
        chk({tag, ".fall"},    e, sw_fall, fa);
        chk({tag, ".changed"}, e, {15'd0, sw_changed}, {15'd0, ch});
    endtask

    task automatic step(input logic r, input logic [15:0] raw);
        rst    = r;
        sw_raw = raw;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [15:0] raw, input logic [15:0] st,
                       input logic [15:0] ri, input logic [15:0] fa, input logic ch);
        vec_t v;
        v.rst = r; v.raw = raw; v.stable = st; v.rise = ri; v.fall = fa; v.chg = ch;
        vq.push_back(v);
    endtask

    task automatic run_table(input string tag);
        for (int k = 0; k < vq.size(); k++) begin
            step(vq[k].rst, vq[k].raw);
            chk_main(tag, k, vq[k].stable, vq[k].rise, vq[k].fall, vq[k].chg);
        end
        vq.delete();
    endtask

    initial begin
        rst    = 1'b1;
        sw_raw = 16'h0000;

        // Reset for three cycles, then twenty idle cycles.
        for (int k = 0; k < 3; k++)  add(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        for (int k = 0; k < 20; k++) add(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        run_table("reset_idle");

        // Single bit rise: new level visible at edge 9, strobes for that one cycle.
        for (int k = 0; k < 9; k++) add(1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        add(1'b0, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 1'b1);
        add(1'b0, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0);
        add(1'b0, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0);
        run_table("rise1");

        // Bounce on bit 1: high 5, low 3, then high from edge 8 -> settles at edge 17.
        for (int e = 0; e <= 18; e++) begin
            step(1'b0, (e >= 5 && e < 8) ? 16'h0001 : 16'h0003);
            if (e < 17)       chk_main("bounce", e, 16'h0001, 16'h0000, 16'h0000, 1'b0);
            else if (e == 17) chk_main("bounce", e, 16'h0003, 16'h0002, 16'h0000, 1'b1);
            else              chk_main("bounce", e, 16'h0003, 16'h0000, 16'h0000, 1'b0);
        end

        // Reset dominates a pending mismatch, then six bits rise together.
        add(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        add(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        for (int k = 0; k < 9; k++) add(1'b0, 16'h003F, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        add(1'b0, 16'h003F, 16'h003F, 16'h003F, 16'h0000, 1'b1);
        add(1'b0, 16'h003F, 16'h003F, 16'h0000, 16'h0000, 1'b0);
        add(1'b0, 16'h003F, 16'h003F, 16'h0000, 16'h0000, 1'b0);
        run_table("multi_rise");

        // Fall on bit 5 only.
        for (int k = 0; k < 9; k++) add(1'b0, 16'h001F, 16'h003F, 16'h0000, 16'h0000, 1'b0);
        add(1'b0, 16'h001F, 16'h001F, 16'h0000, 16'h0020, 1'b1);
        add(1'b0, 16'h001F, 16'h001F, 16'h0000, 16'h0000, 1'b0);
        run_table("fall5");

        // Reset mid-count: rst at edge 6, first low edge is 7, stable rises at edge 16.
        add(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        add(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        run_table("pre_midrst");
        for (int e = 0; e <= 17; e++) begin
            step((e == 6), 16'h0004);
            if (e < 16)       chk_main("midrst", e, 16'h0000, 16'h0000, 16'h0000, 1'b0);
            else if (e == 16) chk_main("midrst", e, 16'h0004, 16'h0004, 16'h0000, 1'b1);
            else              chk_main("midrst", e, 16'h0004, 16'h0000, 16'h0000, 1'b0);
        end

        // DEBOUNCE_CYCLES=1 instance: update at edge 2, then a fall at edge 2 after release.
        step(1'b1, 16'h0000);
        chk("fast.reset", 0, q_stable, 16'h0000);
        for (int e = 0; e <= 3; e++) begin
            step(1'b0, 16'h8000);
            chk("fast.stable", e, q_stable, (e >= 2) ? 16'h8000 : 16'h0000);
            chk("fast.rise",   e, q_rise,   (e == 2) ? 16'h8000 : 16'h0000);
            chk("fast.changed", e, {15'd0, q_changed}, {15'd0, (e == 2)});
        end
        for (int e = 0; e <= 3; e++) begin
            step(1'b0, 16'h0000);
            chk("fast.fstable", e, q_stable, (e >= 2) ? 16'h0000 : 16'h8000);
            chk("fast.fall",    e, q_fall,   (e == 2) ? 16'h8000 : 16'h0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout edge=0 got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
